// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU control codes, RV32 opcode/funct fields and decode result type
package alu_ctrl_pkg;
  localparam logic [3:0] ALUCTRL_AND  = 4'd0;
  localparam logic [3:0] ALUCTRL_XOR  = 4'd1;
  localparam logic [3:0] ALUCTRL_SLL  = 4'd2;
  localparam logic [3:0] ALUCTRL_ADD  = 4'd3;
  localparam logic [3:0] ALUCTRL_SUB  = 4'd4;
  localparam logic [3:0] ALUCTRL_MUL  = 4'd5;
  localparam logic [3:0] ALUCTRL_ADDI = 4'd6;
  localparam logic [3:0] ALUCTRL_SRAI = 4'd7;
  localparam logic [3:0] ALUCTRL_LW   = 4'd8;
  localparam logic [3:0] ALUCTRL_SW   = 4'd9;
  localparam logic [3:0] ALUCTRL_BEQ  = 4'd10;
  localparam logic [3:0] ALUCTRL_NOP  = 4'd15;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_SRA = 3'b101;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;
  typedef enum logic [1:0] {IMM_RS2, IMM_I, IMM_SHAMT, IMM_S} imm_sel_e;
  typedef struct packed {
    logic [3:0] ctrl;
    imm_sel_e   imm_sel;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       illegal;
  } dec_t;
  localparam dec_t DEC_BUBBLE = '{ALUCTRL_NOP, IMM_RS2, 1'b0, 1'b0, 1'b0, 1'b1};
  function automatic dec_t dec_ok(logic [3:0] c, imm_sel_e s, logic rw, logic mr, logic mw);
    return '{c, s, rw, mr, mw, 1'b0};
  endfunction
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: opcode/funct3/funct7 -> ALU code, operand-2 select, enables, illegal
//   op_i  [6:0]  opcode field
//   f3_i  [2:0]  funct3 field
//   f7_i  [6:0]  funct7 field (also imm[11:5] for srai)
//   dec_o        decoded control; anything unlisted comes back as an illegal bubble
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] f3_i,
  input  logic [6:0] f7_i,
  output dec_t       dec_o
);
  always_comb begin
    dec_o = DEC_BUBBLE;
    case (op_i)
      OPC_OP:
        if (f7_i == F7_BASE && f3_i == F3_AND) dec_o = dec_ok(ALUCTRL_AND, IMM_RS2, 1'b1, 1'b0, 1'b0);
        else if (f7_i == F7_BASE && f3_i == F3_XOR) dec_o = dec_ok(ALUCTRL_XOR, IMM_RS2, 1'b1, 1'b0, 1'b0);
        else if (f7_i == F7_BASE && f3_i == F3_SLL) dec_o = dec_ok(ALUCTRL_SLL, IMM_RS2, 1'b1, 1'b0, 1'b0);
        else if (f7_i == F7_BASE && f3_i == F3_ADD) dec_o = dec_ok(ALUCTRL_ADD, IMM_RS2, 1'b1, 1'b0, 1'b0);
        else if (f7_i == F7_ALT && f3_i == F3_ADD) dec_o = dec_ok(ALUCTRL_SUB, IMM_RS2, 1'b1, 1'b0, 1'b0);
        else if (f7_i == F7_MUL && f3_i == F3_ADD) dec_o = dec_ok(ALUCTRL_MUL, IMM_RS2, 1'b1, 1'b0, 1'b0);
      OPC_OPIMM:
        if (f3_i == F3_ADD) dec_o = dec_ok(ALUCTRL_ADDI, IMM_I, 1'b1, 1'b0, 1'b0);
        else if (f3_i == F3_SRA && f7_i == F7_ALT) dec_o = dec_ok(ALUCTRL_SRAI, IMM_SHAMT, 1'b1, 1'b0, 1'b0);
      OPC_LOAD:
        if (f3_i == F3_W) dec_o = dec_ok(ALUCTRL_LW, IMM_I, 1'b1, 1'b1, 1'b0);
      OPC_STORE:
        if (f3_i == F3_W) dec_o = dec_ok(ALUCTRL_SW, IMM_S, 1'b0, 1'b0, 1'b1);
      OPC_BRANCH:
        if (f3_i == F3_BEQ) dec_o = dec_ok(ALUCTRL_BEQ, IMM_RS2, 1'b0, 1'b0, 1'b0);
      default: dec_o = DEC_BUBBLE;
    endcase
  end
endmodule

// File: rtl/id_ex_alu_issue.sv
// id_ex_alu_issue: decodes one RV32 instruction per cycle into ALU code + operands, held in the ID/EX register
//   clk_i, rst_i (async, active-high)
//   valid_i, instr_i, rs1_data_i, rs2_data_i   ID-stage instruction and register reads
//   stall_i (hold), flush_i (bubble, wins over stall)
//   valid_o, ALUCtrl_o, data1_o, data2_o, rs2_store_o, rd_o, reg_write_o, mem_read_o, mem_write_o
//   illegal_o   sticky until reset once an unsupported instruction is issued
module id_ex_alu_issue
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [31:0]       instr_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic [XLEN-1:0]   data1_o,
  output logic [XLEN-1:0]   data2_o,
  output logic [XLEN-1:0]   rs2_store_o,
  output logic [4:0]        rd_o,
  output logic              reg_write_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              illegal_o
);
  dec_t dec;
  logic unused_rs1_field;
  logic [XLEN-1:0] op2;
  logic load, en;
  logic valid_q, valid_d, rw_q, rw_d, mr_q, mr_d, mw_q, mw_d, ill_q, ill_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [XLEN-1:0] d1_q, d1_d, d2_q, d2_d, st_q, st_d;
  logic [4:0] rd_q, rd_d;
  alu_ctrl_decode u_dec (
    .op_i  (instr_i[6:0]),
    .f3_i  (instr_i[14:12]),
    .f7_i  (instr_i[31:25]),
    .dec_o (dec)
  );
  assign unused_rs1_field = ^instr_i[19:15];
  assign op2 = dec.imm_sel == IMM_I     ? {{(XLEN-12){instr_i[31]}}, instr_i[31:20]} :
               dec.imm_sel == IMM_SHAMT ? {{(XLEN-5){1'b0}}, instr_i[24:20]} :
               dec.imm_sel == IMM_S     ? {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]} :
                                          rs2_data_i;
  // flush forces a register write (of a bubble) even while stalled
  assign en    = flush_i | ~stall_i;
  assign load  = valid_i & ~flush_i & ~dec.illegal;
  assign ill_d = ill_q | (valid_i & dec.illegal & ~flush_i & ~stall_i);
  always_comb begin
    valid_d = load;
    ctrl_d  = load ? CTRL_W'(dec.ctrl) : CTRL_W'(ALUCTRL_NOP);
    d1_d    = load ? rs1_data_i : '0;
    d2_d    = load ? op2 : '0;
    st_d    = load ? rs2_data_i : '0;
    rd_d    = load && dec.reg_write ? instr_i[11:7] : 5'd0;
    rw_d    = load & dec.reg_write;
    mr_d    = load & dec.mem_read;
    mw_d    = load & dec.mem_write;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_W'(ALUCTRL_NOP);
      d1_q    <= '0;
      d2_q    <= '0;
      st_q    <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      ill_q <= ill_d;
      if (en) begin
        valid_q <= valid_d;
        ctrl_q  <= ctrl_d;
        d1_q    <= d1_d;
        d2_q    <= d2_d;
        st_q    <= st_d;
        rd_q    <= rd_d;
        rw_q    <= rw_d;
        mr_q    <= mr_d;
        mw_q    <= mw_d;
      end
    end
  end
  assign valid_o     = valid_q;
  assign ALUCtrl_o   = ctrl_q;
  assign data1_o     = d1_q;
  assign data2_o     = d2_q;
  assign rs2_store_o = st_q;
  assign rd_o        = rd_q;
  assign reg_write_o = rw_q;
  assign mem_read_o  = mr_q;
  assign mem_write_o = mw_q;
  assign illegal_o   = ill_q;
endmodule

// File: tb/tb_id_ex_alu_issue.sv
// tb_id_ex_alu_issue: directed vectors, expected ID/EX contents queued per issue and checked by a monitor
module tb_id_ex_alu_issue;
  typedef struct packed {
    logic        v;
    logic [3:0]  c;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] st;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        ill;
  } exp_t;
  typedef struct {
    int    due;
    exp_t  e;
    string name;
  } item_t;
  logic clk = 1'b0, rst_i = 1'b1, valid_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
  logic [31:0] instr_i = '0, rs1_data_i = '0, rs2_data_i = '0;
  logic valid_o, reg_write_o, mem_read_o, mem_write_o, illegal_o;
  logic [3:0] ALUCtrl_o;
  logic [31:0] data1_o, data2_o, rs2_store_o;
  logic [4:0] rd_o;
  item_t q[$];
  int checks = 0, failures = 0, cyc = 0;
  id_ex_alu_issue #(.XLEN(32), .CTRL_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .instr_i(instr_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_o(valid_o), .ALUCtrl_o(ALUCtrl_o), .data1_o(data1_o), .data2_o(data2_o),
    .rs2_store_o(rs2_store_o), .rd_o(rd_o), .reg_write_o(reg_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .illegal_o(illegal_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic exp_t mk(logic v, logic [3:0] c, logic [31:0] d1, logic [31:0] d2, logic [31:0] st,
                              logic [4:0] rd, logic rw, logic mr, logic mw, logic ill);
    return '{v, c, d1, d2, st, rd, rw, mr, mw, ill};
  endfunction
  function automatic exp_t bub(logic ill);
    return mk(1'b0, 4'd15, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, ill);
  endfunction
  function automatic exp_t cur();
    return '{valid_o, ALUCtrl_o, data1_o, data2_o, rs2_store_o, rd_o, reg_write_o, mem_read_o, mem_write_o, illegal_o};
  endfunction
  task automatic compare(string nm, exp_t a, exp_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got v=%0d ctrl=%0d d1=%h d2=%h st=%h rd=%0d rw=%0d mr=%0d mw=%0d ill=%0d | exp v=%0d ctrl=%0d d1=%h d2=%h st=%h rd=%0d rw=%0d mr=%0d mw=%0d ill=%0d",
               nm, a.v, a.c, a.d1, a.d2, a.st, a.rd, a.rw, a.mr, a.mw, a.ill,
               e.v, e.c, e.d1, e.d2, e.st, e.rd, e.rw, e.mr, e.mw, e.ill);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      item_t it;
      it = q.pop_front();
      compare(it.name, cur(), it.e);
    end
  end
  task automatic drive(string nm, logic v, logic [31:0] ins, logic [31:0] r1, logic [31:0] r2,
                       logic st, logic fl, exp_t e);
    @(posedge clk);
    #1;
    valid_i = v; instr_i = ins; rs1_data_i = r1; rs2_data_i = r2; stall_i = st; flush_i = fl;
    q.push_back('{cyc + 1, e, nm});
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
      q.delete();
    end
  endtask
  task automatic rst_pulse(string nm);
    #1 rst_i = 1'b1;
    #1 compare(nm, cur(), bub(1'b0));
    #1 rst_i = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog_timeout time=%0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    #12 compare("reset_state", cur(), bub(1'b0));
    @(negedge clk);
    rst_i = 1'b0;
    drive("add",   1, 32'h002081B3, 32'd5,        32'd7,    0, 0, mk(1, 3, 32'd5, 32'd7, 32'd7, 5'd3, 1, 0, 0, 0));
    drive("addi",  1, 32'hFFF00093, 32'd0,        32'h55,   0, 0, mk(1, 6, 32'd0, 32'hFFFFFFFF, 32'h55, 5'd1, 1, 0, 0, 0));
    drive("srai",  1, 32'h4030D113, 32'hFFFFFFF0, 32'h11,   0, 0, mk(1, 7, 32'hFFFFFFF0, 32'd3, 32'h11, 5'd2, 1, 0, 0, 0));
    drive("lw",    1, 32'hFFC0A283, 32'h1000,     32'd9,    0, 0, mk(1, 8, 32'h1000, 32'hFFFFFFFC, 32'd9, 5'd5, 1, 1, 0, 0));
    drive("beq",   1, 32'h00208463, 32'd1,        32'd2,    0, 0, mk(1, 10, 32'd1, 32'd2, 32'd2, 5'd0, 0, 0, 0, 0));
    drive("sub",   1, 32'h402081B3, 32'd9,        32'd4,    0, 0, mk(1, 4, 32'd9, 32'd4, 32'd4, 5'd3, 1, 0, 0, 0));
    drive("and",   1, 32'h0020F1B3, 32'hC,        32'hA,    0, 0, mk(1, 0, 32'hC, 32'hA, 32'hA, 5'd3, 1, 0, 0, 0));
    drive("xor",   1, 32'h0020C1B3, 32'hC,        32'hA,    0, 0, mk(1, 1, 32'hC, 32'hA, 32'hA, 5'd3, 1, 0, 0, 0));
    drive("sll",   1, 32'h002091B3, 32'hC,        32'hA,    0, 0, mk(1, 2, 32'hC, 32'hA, 32'hA, 5'd3, 1, 0, 0, 0));
    drive("no_valid", 0, 32'h002081B3, 32'd5,     32'd7,    0, 0, bub(1'b0));
    drive("sw_neg", 1, 32'hFE20AE23, 32'h200,     32'h77,   0, 0, mk(1, 9, 32'h200, 32'hFFFFFFFC, 32'h77, 5'd0, 0, 0, 1, 0));
    drive("sw",    1, 32'h0020A423, 32'h100,      32'hAB,   0, 0, mk(1, 9, 32'h100, 32'd8, 32'hAB, 5'd0, 0, 0, 1, 0));
    drain();
    rst_pulse("rst_async_mid_cycle");
    drive("mul",   1, 32'h022081B3, 32'd6,        32'd7,    0, 0, mk(1, 5, 32'd6, 32'd7, 32'd7, 5'd3, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      drive("stall_hold", 1, 32'h002081B3, 32'd1, 32'd1, 1, 0, mk(1, 5, 32'd6, 32'd7, 32'd7, 5'd3, 1, 0, 0, 0));
    drive("flush_with_stall", 1, 32'h002081B3, 32'd1, 32'd1, 1, 1, bub(1'b0));
    drive("illegal", 1, 32'hFFFFFFFF, 32'd1,      32'd2,    0, 0, bub(1'b1));
    for (int i = 1; i <= 10; i++)
      drive("sticky_add", 1, 32'h002081B3, 32'(i), 32'(2 * i), 0, 0, mk(1, 3, 32'(i), 32'(2 * i), 32'(2 * i), 5'd3, 1, 0, 0, 1));
    drain();
    stall_i = 1'b1;
    rst_pulse("rst_during_stall");
    drive("add_after_rst", 1, 32'h002081B3, 32'd5, 32'd7,   0, 0, mk(1, 3, 32'd5, 32'd7, 32'd7, 5'd3, 1, 0, 0, 0));
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
